// File: rtl/insight_dcache_req_trace_buf.sv
// Multi-port DCache request trace capture buffer: filters retiring requests, tags them
// with source port and a global sequence number, and queues them for a trace encoder.
module insight_dcache_req_trace_buf #(
   parameter int NUM_PORTS = 2,
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int ID_W      = 6,
   parameter int DEPTH     = 8,
   parameter int SEQ_W     = 16,
   localparam int MASK_W   = DATA_W / 8,
   localparam int PORT_W   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
   localparam int PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int LVL_W    = $clog2(DEPTH) + 1
) (
   input  logic                          clock,
   input  logic                          reset_n,
   input  logic                          enable,
   input  logic [31:0]                   cmd_filter,
   input  logic [NUM_PORTS-1:0]          in_valid,
   input  logic [NUM_PORTS*ADDR_W-1:0]   in_addr,
   input  logic [NUM_PORTS*MASK_W-1:0]   in_wmask,
   input  logic [NUM_PORTS*DATA_W-1:0]   in_wdata,
   input  logic [NUM_PORTS*ID_W-1:0]     in_id,
   input  logic [NUM_PORTS*5-1:0]        in_cmd,
   input  logic [NUM_PORTS-1:0]          in_signed,
   input  logic [NUM_PORTS*2-1:0]        in_size,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [PORT_W-1:0]             out_port,
   output logic [SEQ_W-1:0]              out_seq,
   output logic [ADDR_W-1:0]             out_addr,
   output logic [MASK_W-1:0]             out_wmask,
   output logic [DATA_W-1:0]             out_wdata,
   output logic [ID_W-1:0]               out_id,
   output logic [4:0]                    out_cmd,
   output logic                          out_signed,
   output logic [1:0]                    out_size,
   output logic [15:0]                   drop_count,
   output logic                          overflow,
   output logic [LVL_W-1:0]              level
);

   typedef struct packed {
      logic [PORT_W-1:0] port;
      logic [SEQ_W-1:0]  seq;
      logic [ADDR_W-1:0] addr;
      logic [MASK_W-1:0] wmask;
      logic [DATA_W-1:0] wdata;
      logic [ID_W-1:0]   id;
      logic [4:0]        cmd;
      logic              sgn;
      logic [1:0]        size;
   } rec_t;

   rec_t              mem [DEPTH];
   rec_t              in_rec [NUM_PORTS];
   logic [PTR_W-1:0]  wr_slot [NUM_PORTS];
   logic [NUM_PORTS-1:0] accept;
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [SEQ_W-1:0]  seq_ctr;
   logic [LVL_W-1:0]  free_slots;
   logic [LVL_W-1:0]  n_elig;
   logic [LVL_W-1:0]  n_acc;
   logic [LVL_W-1:0]  n_drop;
   logic [16:0]       drop_sum;
   logic              deq;
   rec_t              head;

   assign free_slots = LVL_W'(DEPTH) - level;
   assign deq        = out_valid && out_ready;
   assign drop_sum   = {1'b0, drop_count} + 17'(n_drop);

   // Eligible ports are numbered and placed in ascending index order; space is judged
   // against the registered level only, so a same-cycle dequeue never frees a slot.
   always_comb begin
      n_elig = '0;
      n_acc  = '0;
      n_drop = '0;
      accept = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         in_rec[p].port  = PORT_W'(p);
         in_rec[p].seq   = seq_ctr + SEQ_W'(n_elig);
         in_rec[p].addr  = in_addr[p*ADDR_W +: ADDR_W];
         in_rec[p].wmask = in_wmask[p*MASK_W +: MASK_W];
         in_rec[p].wdata = in_wdata[p*DATA_W +: DATA_W];
         in_rec[p].id    = in_id[p*ID_W +: ID_W];
         in_rec[p].cmd   = in_cmd[p*5 +: 5];
         in_rec[p].sgn   = in_signed[p];
         in_rec[p].size  = in_size[p*2 +: 2];
         wr_slot[p]      = wr_ptr + n_acc[PTR_W-1:0];
         if (enable && in_valid[p] && cmd_filter[in_cmd[p*5 +: 5]] && (in_cmd[p*5 +: 5] < 5'd21)) begin
            n_elig = n_elig + 1'b1;
            if (n_acc < free_slots) begin
               accept[p] = 1'b1;
               n_acc     = n_acc + 1'b1;
            end else begin
               n_drop = n_drop + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (accept[p]) mem[wr_slot[p]] <= in_rec[p];
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         level      <= '0;
         seq_ctr    <= '0;
         drop_count <= '0;
         overflow   <= 1'b0;
      end else begin
         wr_ptr  <= wr_ptr + n_acc[PTR_W-1:0];
         level   <= level + n_acc - LVL_W'(deq);
         seq_ctr <= seq_ctr + SEQ_W'(n_elig);
         if (deq) rd_ptr <= rd_ptr + 1'b1;
         if (n_drop != '0) begin
            overflow   <= 1'b1;
            drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
         end
      end
   end

   // Head fields are forced to zero while empty so stale storage never leaks out.
   assign out_valid  = (level != '0);
   assign head       = mem[rd_ptr];
   assign out_port   = out_valid ? head.port  : '0;
   assign out_seq    = out_valid ? head.seq   : '0;
   assign out_addr   = out_valid ? head.addr  : '0;
   assign out_wmask  = out_valid ? head.wmask : '0;
   assign out_wdata  = out_valid ? head.wdata : '0;
   assign out_id     = out_valid ? head.id    : '0;
   assign out_cmd    = out_valid ? head.cmd   : '0;
   assign out_signed = out_valid ? head.sgn   : 1'b0;
   assign out_size   = out_valid ? head.size  : '0;

endmodule

// File: tb/tb_insight_dcache_req_trace_buf.sv
// Directed self-checking bench for insight_dcache_req_trace_buf (2 ports, depth 8, 4-bit seq).
module tb_insight_dcache_req_trace_buf;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        enable;
   logic [31:0] cmd_filter;
   logic [1:0]  in_valid;
   logic [63:0] in_addr;
   logic [7:0]  in_wmask;
   logic [63:0] in_wdata;
   logic [11:0] in_id;
   logic [9:0]  in_cmd;
   logic [1:0]  in_signed;
   logic [3:0]  in_size;
   logic        out_valid;
   logic        out_ready;
   logic        out_port;
   logic [3:0]  out_seq;
   logic [31:0] out_addr;
   logic [3:0]  out_wmask;
   logic [31:0] out_wdata;
   logic [5:0]  out_id;
   logic [4:0]  out_cmd;
   logic        out_signed;
   logic [1:0]  out_size;
   logic [15:0] drop_count;
   logic        overflow;
   logic [3:0]  level;

   int check_count = 0;
   int fail_count  = 0;

   insight_dcache_req_trace_buf #(
      .NUM_PORTS(2), .ADDR_W(32), .DATA_W(32), .ID_W(6), .DEPTH(8), .SEQ_W(4)
   ) dut (
      .clock(clock), .reset_n(reset_n), .enable(enable), .cmd_filter(cmd_filter),
      .in_valid(in_valid), .in_addr(in_addr), .in_wmask(in_wmask), .in_wdata(in_wdata),
      .in_id(in_id), .in_cmd(in_cmd), .in_signed(in_signed), .in_size(in_size),
      .out_valid(out_valid), .out_ready(out_ready), .out_port(out_port), .out_seq(out_seq),
      .out_addr(out_addr), .out_wmask(out_wmask), .out_wdata(out_wdata), .out_id(out_id),
      .out_cmd(out_cmd), .out_signed(out_signed), .out_size(out_size),
      .drop_count(drop_count), .overflow(overflow), .level(level)
   );

   always #5 clock = ~clock;

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      check_count++;
      if (got !== exp) begin
         fail_count++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic setPort(input int p, input logic [4:0] cmd, input logic [31:0] addr,
                          input logic [3:0] wmask, input logic [31:0] wdata, input logic [5:0] id);
      in_valid[p]          = 1'b1;
      in_cmd[p*5 +: 5]     = cmd;
      in_addr[p*32 +: 32]  = addr;
      in_wmask[p*4 +: 4]   = wmask;
      in_wdata[p*32 +: 32] = wdata;
      in_id[p*6 +: 6]      = id;
      in_signed[p]         = 1'b0;
      in_size[p*2 +: 2]    = 2'd2;
   endtask

   // One clock: inputs set beforehand are captured, then valids drop; sampling is 1ns after the edge.
   task automatic applyStimulus();
      @(posedge clock);
      #1;
      in_valid = '0;
   endtask

   task automatic doReset();
      in_valid  = '0;
      in_addr   = '0;
      in_wmask  = '0;
      in_wdata  = '0;
      in_id     = '0;
      in_cmd    = '0;
      in_signed = '0;
      in_size   = '0;
      out_ready = 1'b0;
      reset_n   = 1'b0;
      #2;
      reset_n   = 1'b1;
   endtask

   logic [3:0] exp_seq [8];
   logic       exp_port [8];

   initial begin
      enable     = 1'b1;
      cmd_filter = 32'h0000_0002;
      doReset();
      reset_n = 1'b0;
      #1;
      checkOutput("rst_valid", 64'(out_valid), 64'd0);
      checkOutput("rst_level", 64'(level), 64'd0);
      checkOutput("rst_drop", 64'(drop_count), 64'd0);
      checkOutput("rst_ovf", 64'(overflow), 64'd0);
      @(posedge clock);
      #1;
      reset_n = 1'b1;

      // Single store
      setPort(0, 5'd1, 32'h8000_0010, 4'hF, 32'hDEAD_BEEF, 6'd5);
      applyStimulus();
      checkOutput("st_valid", 64'(out_valid), 64'd1);
      checkOutput("st_seq", 64'(out_seq), 64'd0);
      checkOutput("st_port", 64'(out_port), 64'd0);
      checkOutput("st_addr", 64'(out_addr), 64'h8000_0010);
      checkOutput("st_wmask", 64'(out_wmask), 64'hF);
      checkOutput("st_wdata", 64'(out_wdata), 64'hDEAD_BEEF);
      checkOutput("st_id", 64'(out_id), 64'd5);
      checkOutput("st_cmd", 64'(out_cmd), 64'd1);
      checkOutput("st_size", 64'(out_size), 64'd2);
      out_ready = 1'b1;
      applyStimulus();
      out_ready = 1'b0;
      checkOutput("st_drain_level", 64'(level), 64'd0);
      checkOutput("st_empty_addr", 64'(out_addr), 64'd0);

      // Dual simultaneous capture
      doReset();
      cmd_filter = 32'h0000_0001;
      setPort(0, 5'd0, 32'h100, 4'h0, 32'h0, 6'd1);
      setPort(1, 5'd0, 32'h200, 4'h0, 32'h0, 6'd2);
      applyStimulus();
      checkOutput("dual_level", 64'(level), 64'd2);
      checkOutput("dual_h0_port", 64'(out_port), 64'd0);
      checkOutput("dual_h0_seq", 64'(out_seq), 64'd0);
      checkOutput("dual_h0_addr", 64'(out_addr), 64'h100);
      out_ready = 1'b1;
      applyStimulus();
      checkOutput("dual_h1_port", 64'(out_port), 64'd1);
      checkOutput("dual_h1_seq", 64'(out_seq), 64'd1);
      checkOutput("dual_h1_addr", 64'(out_addr), 64'h200);
      applyStimulus();
      out_ready = 1'b0;
      checkOutput("dual_drained", 64'(level), 64'd0);

      // Command filter, disabled capture, and never-captured cmd 21
      doReset();
      cmd_filter = 32'h0000_0001;
      setPort(0, 5'd1, 32'h300, 4'h0, 32'h0, 6'd3);
      setPort(1, 5'd0, 32'h400, 4'h0, 32'h0, 6'd4);
      applyStimulus();
      checkOutput("flt_level", 64'(level), 64'd1);
      checkOutput("flt_port", 64'(out_port), 64'd1);
      checkOutput("flt_seq", 64'(out_seq), 64'd0);
      checkOutput("flt_drop", 64'(drop_count), 64'd0);
      cmd_filter = 32'h0020_0001;
      setPort(0, 5'd21, 32'h500, 4'h0, 32'h0, 6'd0);
      applyStimulus();
      checkOutput("flt_cmd21", 64'(level), 64'd1);
      enable = 1'b0;
      setPort(0, 5'd0, 32'h600, 4'h0, 32'h0, 6'd0);
      applyStimulus();
      enable = 1'b1;
      checkOutput("flt_disabled", 64'(level), 64'd1);
      setPort(0, 5'd0, 32'h700, 4'h0, 32'h0, 6'd0);
      applyStimulus();
      out_ready = 1'b1;
      applyStimulus();
      checkOutput("flt_seq_next", 64'(out_seq), 64'd1);
      applyStimulus();
      out_ready = 1'b0;

      // Overflow and full-with-dequeue
      doReset();
      cmd_filter = 32'h0000_0001;
      for (int i = 0; i < 7; i++) begin
         setPort(0, 5'd0, 32'h1000 + i, 4'h0, 32'h0, 6'd0);
         applyStimulus();
      end
      checkOutput("ovf_fill_level", 64'(level), 64'd7);
      setPort(0, 5'd0, 32'h2000, 4'h0, 32'h0, 6'd0);
      setPort(1, 5'd0, 32'h2001, 4'h0, 32'h0, 6'd0);
      applyStimulus();
      checkOutput("ovf_level", 64'(level), 64'd8);
      checkOutput("ovf_drop", 64'(drop_count), 64'd1);
      checkOutput("ovf_flag", 64'(overflow), 64'd1);
      checkOutput("ovf_head_seq", 64'(out_seq), 64'd0);
      out_ready = 1'b1;
      applyStimulus();
      out_ready = 1'b0;
      setPort(1, 5'd0, 32'h3000, 4'h0, 32'h0, 6'd0);
      applyStimulus();
      checkOutput("ovf_refill_level", 64'(level), 64'd8);
      checkOutput("ovf_refill_drop", 64'(drop_count), 64'd1);
      out_ready = 1'b1;
      setPort(0, 5'd0, 32'h4000, 4'h0, 32'h0, 6'd0);
      applyStimulus();
      checkOutput("full_deq_level", 64'(level), 64'd7);
      checkOutput("full_deq_drop", 64'(drop_count), 64'd2);
      out_ready = 1'b0;
      setPort(0, 5'd0, 32'h5000, 4'h0, 32'h0, 6'd0);
      applyStimulus();
      checkOutput("full_after_level", 64'(level), 64'd8);
      exp_seq  = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd9, 4'd11};
      exp_port = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         checkOutput($sformatf("ovf_drain_seq%0d", i), 64'(out_seq), 64'(exp_seq[i]));
         checkOutput($sformatf("ovf_drain_port%0d", i), 64'(out_port), 64'(exp_port[i]));
         applyStimulus();
      end
      out_ready = 1'b0;
      checkOutput("ovf_drain_level", 64'(level), 64'd0);
      checkOutput("ovf_sticky", 64'(overflow), 64'd1);

      // Asynchronous reset mid-drain
      doReset();
      cmd_filter = 32'h0000_0001;
      for (int i = 0; i < 6; i++) begin
         setPort(0, 5'd0, 32'h6000 + i, 4'h0, 32'h0, 6'd0);
         applyStimulus();
      end
      out_ready = 1'b1;
      applyStimulus();
      checkOutput("ar_pre_level", 64'(level), 64'd5);
      #2;
      reset_n = 1'b0;
      #1;
      checkOutput("ar_valid", 64'(out_valid), 64'd0);
      checkOutput("ar_level", 64'(level), 64'd0);
      checkOutput("ar_drop", 64'(drop_count), 64'd0);
      reset_n = 1'b1;
      out_ready = 1'b0;
      @(posedge clock);
      #1;
      setPort(0, 5'd0, 32'h7000, 4'h0, 32'h0, 6'd0);
      applyStimulus();
      checkOutput("ar_post_seq", 64'(out_seq), 64'd0);
      checkOutput("ar_post_addr", 64'(out_addr), 64'h7000);

      // Sequence wrap with a 4-bit counter
      doReset();
      cmd_filter = 32'h0000_0001;
      out_ready  = 1'b1;
      for (int k = 0; k < 17; k++) begin
         setPort(0, 5'd0, 32'h9000 + k, 4'h0, 32'h0, 6'd0);
         applyStimulus();
         checkOutput($sformatf("wrap_seq%0d", k), 64'(out_seq), 64'(k % 16));
      end
      applyStimulus();
      checkOutput("wrap_drained", 64'(level), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
      $finish;
   end

endmodule
